// File: rtl/softmax_out_packer.sv
// softmax_out_packer
//   Receive-side endpoint for the softmax output byte stream. Bytes are packed
//   little-endian into 32-bit words, buffered in a circular FIFO and presented
//   on an AXI-Stream-style master through a registered output stage.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_data/valid/last  byte stream from the softmax engine (no backpressure)
//   m_tdata/tkeep/tlast/tvalid, m_tready   stream toward the writeback path
//   almost_full       registered flag, fifo_level >= FIFO_DEPTH - AFULL_MARGIN
//   overflow          sticky flag, a completed word was dropped (clear_ovf clears)
//   fifo_level        FIFO occupancy, excluding the output register
//   row_count         number of tlast beats accepted downstream (wraps)
module softmax_out_packer #(
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned AFULL_MARGIN = 8,
  parameter int unsigned LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic [31:0]   m_tdata,
  output logic [3:0]    m_tkeep,
  output logic          m_tlast,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          almost_full,
  output logic          overflow,
  input  logic          clear_ovf,
  output logic [LW-1:0] fifo_level,
  output logic [15:0]   row_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // Packer state
  logic [1:0]  idx_q;
  logic [31:0] pack_q;
  logic [3:0]  keep_q;
  logic [31:0] pack_word;
  logic [3:0]  keep_word;
  logic        push;
  logic [36:0] push_entry;

  // FIFO state
  logic [36:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          fifo_empty, fifo_full;
  logic          pop, wr_en, drop;
  logic [36:0]   head;

  // Output register and status
  logic        ovalid_q;
  logic [31:0] odata_q;
  logic [3:0]  okeep_q;
  logic        olast_q;
  logic        afull_q;
  logic        ovf_q;
  logic [15:0] rows_q;

  // Current byte merged into the partial word; pushed when lane 3 fills or the row ends.
  always_comb begin
    pack_word = pack_q;
    keep_word = keep_q;
    for (int k = 0; k < 4; k++) begin
      if (idx_q == 2'(k)) begin
        pack_word[8*k +: 8] = in_data;
        keep_word[k]        = 1'b1;
      end
    end
    push       = in_valid && ((idx_q == 2'd3) || in_last);
    push_entry = {in_last, keep_word, pack_word};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      pack_q <= '0;
      keep_q <= '0;
    end else if (in_valid) begin
      if (push) begin
        idx_q  <= '0;
        pack_q <= '0;
        keep_q <= '0;
      end else begin
        idx_q  <= idx_q + 2'd1;
        pack_q <= pack_word;
        keep_q <= keep_word;
      end
    end
  end

  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LW'(FIFO_DEPTH));
    head       = mem[rptr_q];
    // Refill the output stage whenever it is empty or its word is leaving.
    pop        = !fifo_empty && (!ovalid_q || m_tready);
    // A full FIFO still accepts a word if a slot frees up on the same edge.
    wr_en      = push && (!fifo_full || pop);
    drop       = push && fifo_full && !pop;
    level_d    = level_q + LW'(wr_en) - LW'(pop);
  end

  // Storage array has no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (pop)   rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      afull_q <= (level_d >= LW'(FIFO_DEPTH - AFULL_MARGIN));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      okeep_q  <= '0;
      olast_q  <= 1'b0;
    end else if (pop) begin
      ovalid_q <= 1'b1;
      olast_q  <= head[36];
      okeep_q  <= head[35:32];
      odata_q  <= head[31:0];
    end else if (ovalid_q && m_tready) begin
      ovalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      rows_q <= '0;
    end else begin
      // Set wins over a simultaneous clear.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clear_ovf) begin
        ovf_q <= 1'b0;
      end
      if (ovalid_q && m_tready && olast_q) begin
        rows_q <= rows_q + 16'd1;
      end
    end
  end

  assign m_tdata     = odata_q;
  assign m_tkeep     = okeep_q;
  assign m_tlast     = olast_q;
  assign m_tvalid    = ovalid_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
  assign fifo_level  = level_q;
  assign row_count   = rows_q;

endmodule
